// File: rtl/io_mmio_controller_pkg.sv
// Address map shared by the IO slave and its sub-blocks.
// Port summary: none (package of constants only).
// Offsets decode addr[7:0] inside the region selected by addr[31:28].
package io_mmio_controller_pkg;

    localparam logic [3:0] IO_REGION     = 4'h8;

    localparam logic [7:0] OFF_UART_CTRL = 8'h00;
    localparam logic [7:0] OFF_UART_RX   = 8'h04;
    localparam logic [7:0] OFF_UART_TX   = 8'h08;
    localparam logic [7:0] OFF_CYC_CNT   = 8'h10;
    localparam logic [7:0] OFF_INST_CNT  = 8'h14;
    localparam logic [7:0] OFF_CNT_RST   = 8'h18;

endpackage

// File: rtl/io_rx_fifo.sv
// Purpose: synchronous byte FIFO buffering UART RX bytes until software reads them.
// Latency: push visible on pop_data_o the cycle after the push; pop_data_o shows the head combinationally.
// Backpressure: full_o blocks pushes, empty_o blocks pops; push and pop in one cycle keep occupancy.
// Ports: clk_i, rst_n_i (sync, active-low), push_i/push_data_i, pop_i/pop_data_o, full_o, empty_o.
module io_rx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       push_i,
    input  logic [7:0] push_data_i,
    input  logic       pop_i,
    output logic [7:0] pop_data_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [OCC_W-1:0] occ_q,  occ_d;
    logic             do_push, do_pop;

    assign full_o     = (occ_q == OCC_W'(DEPTH));
    assign empty_o    = (occ_q == '0);
    assign pop_data_o = mem_q[rptr_q];

    // Guard here as well so a caller that ignores full/empty cannot corrupt state.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i  & ~empty_o;

    // DEPTH is a power of two, so pointer increments wrap on their own.
    always_comb begin
        wptr_d = do_push ? wptr_q + PTR_W'(1) : wptr_q;
        rptr_d = do_pop  ? rptr_q + PTR_W'(1) : rptr_q;
        occ_d  = occ_q;
        if (do_push && !do_pop) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (do_pop && !do_push) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            occ_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            occ_q  <= occ_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/io_mmio_controller.sv
// Purpose: MMIO slave for region 0x8xxxxxxx: UART RX FIFO / TX holding register, cycle and retired-instruction counters.
// Latency: load data registered on io_rdata one cycle after rd_en, held until the next rd_en.
// Backpressure: uart_rx_ready = FIFO not full; TX writes while uart_tx_valid is set are dropped.
// Ports: clk/rst_n (sync, active-low), pipeline side addr/rd_en/wr_en/wdata/be/inst_retired -> io_rdata,
//        UART side uart_rx_data/valid/ready and uart_tx_data/valid/ready.
module io_mmio_controller
    import io_mmio_controller_pkg::*;
#(
    parameter int RX_DEPTH = 8,
    parameter int CNT_W    = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    input  logic        inst_retired,
    output logic [31:0] io_rdata,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        uart_rx_ready,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready
);

    logic [31:0]      io_rdata_q, io_rdata_d;
    logic             tx_valid_q, tx_valid_d;
    logic [7:0]       tx_data_q,  tx_data_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] inst_cnt_q,  inst_cnt_d;

    logic       io_sel;
    logic [7:0] off;
    logic       rd_ok;
    logic       wr_ok;
    logic       rx_full, rx_empty, rx_pop;
    logic [7:0] rx_head;
    logic       unused_bits;

    assign io_sel = (addr[31:28] == IO_REGION);
    assign off    = addr[7:0];
    // A read colliding with a write is treated as a write; the read returns 0.
    assign rd_ok  = rd_en & io_sel & ~wr_en;
    assign wr_ok  = wr_en & io_sel;
    assign rx_pop = rd_ok & (off == OFF_UART_RX) & ~rx_empty;

    assign unused_bits = ^{addr[27:8], wdata[31:8], be[3:1]};

    io_rx_fifo #(
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .push_i      (uart_rx_valid),
        .push_data_i (uart_rx_data),
        .pop_i       (rx_pop),
        .pop_data_o  (rx_head),
        .full_o      (rx_full),
        .empty_o     (rx_empty)
    );

    assign uart_rx_ready = ~rx_full;
    assign uart_tx_valid = tx_valid_q;
    assign uart_tx_data  = tx_data_q;
    assign io_rdata      = io_rdata_q;

    always_comb begin
        io_rdata_d  = io_rdata_q;
        tx_valid_d  = tx_valid_q;
        tx_data_d   = tx_data_q;
        cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
        inst_cnt_d  = inst_retired ? inst_cnt_q + CNT_W'(1) : inst_cnt_q;

        // Any load updates io_rdata; out-of-region, unmapped or colliding loads return 0.
        if (rd_en) begin
            io_rdata_d = '0;
            if (rd_ok) begin
                case (off)
                    OFF_UART_CTRL: io_rdata_d = {30'b0, ~rx_empty, ~tx_valid_q};
                    OFF_UART_RX:   io_rdata_d = rx_empty ? 32'h0 : {24'b0, rx_head};
                    OFF_CYC_CNT:   io_rdata_d = 32'(cycle_cnt_q);
                    OFF_INST_CNT:  io_rdata_d = 32'(inst_cnt_q);
                    default:       io_rdata_d = '0;
                endcase
            end
        end

        // Busy covers the cycle the held byte is accepted, so such a write is dropped too.
        if (wr_ok && (off == OFF_UART_TX) && be[0] && !tx_valid_q) begin
            tx_valid_d = 1'b1;
            tx_data_d  = wdata[7:0];
        end else if (tx_valid_q && uart_tx_ready) begin
            tx_valid_d = 1'b0;
        end

        // Clear beats increment in the same cycle.
        if (wr_ok && (off == OFF_CNT_RST)) begin
            cycle_cnt_d = '0;
            inst_cnt_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            io_rdata_q  <= '0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= '0;
            cycle_cnt_q <= '0;
            inst_cnt_q  <= '0;
        end else begin
            io_rdata_q  <= io_rdata_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
            cycle_cnt_q <= cycle_cnt_d;
            inst_cnt_q  <= inst_cnt_d;
        end
    end

endmodule

// File: tb/tb_io_mmio_controller.sv
// Bench for io_mmio_controller: directed scenarios then randomized traffic against a queue-based model.
// Counter width is narrowed so wrap-around happens within a short run.
// Expected loads are queued by the driver and checked by an independent monitor.
module tb_io_mmio_controller;

    localparam int DEPTH = 8;
    localparam int CW    = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr;
    logic        rd_en, wr_en;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        inst_retired;
    logic [31:0] io_rdata;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_valid, uart_rx_ready;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid, uart_tx_ready;

    always #5 clk = ~clk;

    io_mmio_controller #(
        .RX_DEPTH (DEPTH),
        .CNT_W    (CW)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .addr          (addr),
        .rd_en         (rd_en),
        .wr_en         (wr_en),
        .wdata         (wdata),
        .be            (be),
        .inst_retired  (inst_retired),
        .io_rdata      (io_rdata),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_ready (uart_rx_ready),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_valid (uart_tx_valid),
        .uart_tx_ready (uart_tx_ready)
    );

    // Reference model state
    logic [7:0]    m_rx [$];
    bit            m_tx_held;
    logic [7:0]    m_tx_byte;
    logic [CW-1:0] m_cyc, m_inst;
    logic [31:0]   exp_rd_q [$];

    // Expected level outputs for the current cycle
    bit            exp_rx_ready, exp_tx_valid;
    logic [7:0]    exp_tx_data;
    bit            chk_en = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [7:0] offs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, advance the model by that edge, return 1 time unit after the edge.
    task automatic step(input bit r, input logic [31:0] a, input bit rd, input bit wr,
                        input logic [31:0] d, input logic [3:0] b, input bit ir,
                        input bit rxv, input logic [7:0] rxd, input bit txr);
        bit          sel;
        logic [7:0]  o;
        logic [31:0] rv;
        int          n;
        bit          push_ok;
        rst_n = r; addr = a; rd_en = rd; wr_en = wr; wdata = d; be = b;
        inst_retired = ir; uart_rx_valid = rxv; uart_rx_data = rxd; uart_tx_ready = txr;
        exp_rx_ready = (m_rx.size() < DEPTH);
        exp_tx_valid = m_tx_held;
        exp_tx_data  = m_tx_byte;
        if (!r) begin
            m_rx.delete();
            m_tx_held = 1'b0;
            m_tx_byte = 8'h00;
            m_cyc     = '0;
            m_inst    = '0;
        end else begin
            sel     = (a[31:28] == 4'h8);
            o       = a[7:0];
            n       = m_rx.size();
            push_ok = rxv && (n < DEPTH);
            rv      = 32'h0;
            if (rd) begin
                if (sel && !wr) begin
                    case (o)
                        8'h00: rv = {30'b0, n != 0, !m_tx_held};
                        8'h04: rv = (n != 0) ? {24'b0, m_rx[0]} : 32'h0;
                        8'h10: rv = 32'(m_cyc);
                        8'h14: rv = 32'(m_inst);
                        default: rv = 32'h0;
                    endcase
                end
                exp_rd_q.push_back(rv);
            end
            if (rd && !wr && sel && o == 8'h04 && n != 0) void'(m_rx.pop_front());
            if (push_ok) m_rx.push_back(rxd);
            if (wr && sel && o == 8'h08 && b[0] && !m_tx_held) begin
                m_tx_held = 1'b1;
                m_tx_byte = d[7:0];
            end else if (m_tx_held && txr) begin
                m_tx_held = 1'b0;
            end
            if (wr && sel && o == 8'h18) begin
                m_cyc  = '0;
                m_inst = '0;
            end else begin
                m_cyc = m_cyc + 1'b1;
                if (ir) m_inst = m_inst + 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1, 32'h0, 0, 0, 32'h0, 4'h0, 0, 0, 8'h00, 0);
    endtask
    task automatic rd_a(input logic [31:0] a);
        step(1, a, 1, 0, 32'h0, 4'h0, 0, 0, 8'h00, 0);
    endtask
    task automatic wr_a(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        step(1, a, 0, 1, d, b, 0, 0, 8'h00, 0);
    endtask
    task automatic push_b(input logic [7:0] v);
        step(1, 32'h0, 0, 0, 32'h0, 4'h0, 0, 1, v, 0);
    endtask

    // Monitor: a load seen at an edge is checked on the following falling edge.
    initial begin
        bit          rd_seen;
        logic [31:0] e;
        forever begin
            @(posedge clk);
            rd_seen = rd_en && rst_n;
            @(negedge clk);
            if (chk_en) begin
                check("rx_ready", {31'b0, uart_rx_ready}, {31'b0, exp_rx_ready});
                check("tx_valid", {31'b0, uart_tx_valid}, {31'b0, exp_tx_valid});
                if (exp_tx_valid) check("tx_data", {24'b0, uart_tx_data}, {24'b0, exp_tx_data});
                if (rd_seen) begin
                    if (exp_rd_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rdata_unexpected actual=%h expected=none", io_rdata);
                    end else begin
                        e = exp_rd_q.pop_front();
                        check("io_rdata", io_rdata, e);
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0] a;
        logic [3:0]  reg_nib;
        int          op;
        bit          r, rd, wr;
        offs[0] = 8'h00; offs[1] = 8'h04; offs[2] = 8'h08; offs[3] = 8'h10;
        offs[4] = 8'h14; offs[5] = 8'h18; offs[6] = 8'h20; offs[7] = 8'h0C;

        // Reset and first counter reads
        step(0, 32'h0, 0, 0, 32'h0, 4'h0, 0, 0, 8'h00, 0);
        chk_en = 1'b1;
        step(0, 32'h0, 0, 0, 32'h0, 4'h0, 0, 0, 8'h00, 0);
        step(0, 32'h0, 0, 0, 32'h0, 4'h0, 0, 0, 8'h00, 0);
        check("reset_rdata",    io_rdata, 32'h0);
        check("reset_tx_data",  {24'b0, uart_tx_data}, 32'h0);
        check("reset_tx_valid", {31'b0, uart_tx_valid}, 32'h0);
        check("reset_rx_ready", {31'b0, uart_rx_ready}, 32'h1);
        rd_a(32'h8000_0010);
        idle(3);
        rd_a(32'h8000_0010);
        idle(1);
        check("cycle_after_reset", io_rdata, 32'h4);

        // RX basic
        push_b(8'h41);
        push_b(8'h42);
        rd_a(32'h8000_0000);
        rd_a(32'h8000_0004);
        rd_a(32'h8000_0004);
        rd_a(32'h8000_0004);
        rd_a(32'h8000_0000);

        // RX full, simultaneous pop+push while full, ordering
        for (int i = 0; i < DEPTH; i++) push_b(8'h60 + 8'(i));
        step(1, 32'h8000_0004, 1, 0, 32'h0, 4'h0, 0, 1, 8'hEE, 0);
        push_b(8'h70);
        for (int i = 0; i < DEPTH + 1; i++) rd_a(32'h8000_0004);

        // TX hold, drop while busy, accept
        wr_a(32'h8000_0008, 32'hABAB_ABAB, 4'b0001);
        wr_a(32'h8000_0008, 32'h0000_0055, 4'b0001);
        rd_a(32'h8000_0000);
        step(1, 32'h0, 0, 0, 32'h0, 4'h0, 0, 0, 8'h00, 1);
        rd_a(32'h8000_0000);
        wr_a(32'h8000_0008, 32'h0000_00C3, 4'b1110);

        // Counters: clear, pulses, clear colliding with a retire
        wr_a(32'h8000_0018, 32'h0, 4'hF);
        repeat (10) step(1, 32'h0, 0, 0, 32'h0, 4'h0, 1, 0, 8'h00, 0);
        rd_a(32'h8000_0014);
        step(1, 32'h8000_0018, 0, 1, 32'h0, 4'hF, 1, 0, 8'h00, 0);
        rd_a(32'h8000_0014);
        rd_a(32'h8000_0010);

        // Wrap and decode
        wr_a(32'h8000_0018, 32'h0, 4'hF);
        idle((1 << CW) - 3);
        repeat (4) rd_a(32'h8000_0010);
        push_b(8'h99);
        rd_a(32'h8000_0020);
        rd_a(32'h1000_0004);
        step(1, 32'h8000_0004, 1, 1, 32'h0, 4'h0, 0, 0, 8'h00, 0);
        wr_a(32'h1000_0008, 32'h0000_0011, 4'b0001);
        rd_a(32'h8000_0004);

        // Reset while a TX byte is pending and the FIFO holds data
        wr_a(32'h8000_0008, 32'h0000_005A, 4'b0001);
        push_b(8'h12);
        step(0, 32'h0, 0, 0, 32'h0, 4'h0, 0, 0, 8'h00, 0);
        check("midreset_rdata", io_rdata, 32'h0);
        rd_a(32'h8000_0000);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reg_nib = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'h8;
            a  = {reg_nib, 20'($urandom), offs[$urandom_range(0, 7)]};
            op = $urandom_range(0, 99);
            r  = ($urandom_range(0, 299) != 0);
            rd = r && (op < 40 || op >= 97);
            wr = (op >= 40 && op < 55) || op >= 97;
            step(r, a, rd, wr, $urandom, 4'($urandom), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 9) < 4, 8'($urandom), $urandom_range(0, 9) < 3);
        end

        idle(2);
        check("rd_queue_drained", 32'(exp_rd_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
